// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and byte/counter widths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int BYTE_W           = 8;
    localparam int GAP_W            = 8;
    localparam int CLKS_PER_BIT_DEF = 217;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index scanning ptr, ptr+1, ... mod NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit modulo keeps non-power-of-2 requester counts from scanning past the end.
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && valid[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources,
// with launch pulse, done/timeout wait and an optional inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic [NUM_REQ-1:0]          i_Req_Valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]          o_Req_Ready,
    output logic [$clog2(NUM_REQ)-1:0]  o_Grant_Id,
    output logic                        o_TX_DV,
    output logic [BYTE_W-1:0]           o_TX_Byte,
    input  logic                        i_TX_Active,
    input  logic                        i_TX_Done,
    output logic                        o_Busy,
    output logic                        o_Timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid  (i_Req_Valid),
        .ptr    (ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    assign ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            o_Req_Ready <= '0;
            o_Grant_Id  <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Busy      <= 1'b0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // The i_TX_Active gate also covers a frame left running across a reset.
                    if (pick_any && !i_TX_Active) begin
                        o_TX_Byte   <= i_Req_Byte[int'(pick_idx)*BYTE_W +: BYTE_W];
                        o_Grant_Id  <= pick_idx;
                        ptr         <= ptr_next;
                        o_Req_Ready <= NUM_REQ'(1) << pick_idx;
                        o_TX_DV     <= 1'b1;
                        o_Busy      <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    o_Req_Ready <= '0;
                    o_TX_DV     <= 1'b0;
                    to_cnt      <= '0;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Done in the final count cycle takes priority over the timeout.
                    if (i_TX_Done || to_cnt == TO_LAST) begin
                        o_Timeout <= !i_TX_Done;
                        gap_cnt   <= '0;
                        if (GAP_CLKS == 0) begin
                            o_Busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state  <= GAP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a 4-requester build (gap 3, timeout 50)
// and a 3-requester build (gap 0) driven with randomized requests against a round-robin model.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_n;

    logic [3:0]  valid_a;
    logic [31:0] byte_a;
    logic [3:0]  ready_a;
    logic [1:0]  gid_a;
    logic        dv_a;
    logic [7:0]  txb_a;
    logic        act_a, done_a, busy_a, to_a;

    logic [2:0]  valid_b;
    logic [23:0] byte_b;
    logic [2:0]  ready_b;
    logic [1:0]  gid_b;
    logic        dv_b;
    logic [7:0]  txb_b;
    logic        act_b, done_b, busy_b, to_b;

    int ptr_a, ptr_b;

    uart_tx_arbiter #(
        .NUM_REQ(4), .CLKS_PER_BIT(217), .GAP_CLKS(3), .TIMEOUT_CLKS(50)
    ) dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Req_Valid(valid_a), .i_Req_Byte(byte_a), .o_Req_Ready(ready_a),
        .o_Grant_Id(gid_a), .o_TX_DV(dv_a), .o_TX_Byte(txb_a),
        .i_TX_Active(act_a), .i_TX_Done(done_a), .o_Busy(busy_a), .o_Timeout(to_a)
    );

    uart_tx_arbiter #(
        .NUM_REQ(3), .CLKS_PER_BIT(217), .GAP_CLKS(0), .TIMEOUT_CLKS(40)
    ) dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Req_Valid(valid_b), .i_Req_Byte(byte_b), .o_Req_Ready(ready_b),
        .o_Grant_Id(gid_b), .o_TX_DV(dv_b), .o_TX_Byte(txb_b),
        .i_TX_Active(act_b), .i_TX_Done(done_b), .o_Busy(busy_b), .o_Timeout(to_b)
    );

    // Reference rule: first valid index found scanning ptr, ptr+1, ... mod n.
    function automatic int rr_expect(input logic [7:0] v, input int ptr, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv_a(input int lim, output int n);
        n = 0;
        while (!dv_a && n < lim) begin tick(); n++; end
    endtask

    task automatic wait_dv_b(input int lim, output int n);
        n = 0;
        while (!dv_b && n < lim) begin tick(); n++; end
    endtask

    task automatic finish_a(input int dly);
        act_a = 1'b1;
        repeat (dly) tick();
        done_a = 1'b1; act_a = 1'b0;
        tick();
        done_a = 1'b0;
    endtask

    task automatic finish_b(input int dly);
        act_b = 1'b1;
        repeat (dly) tick();
        done_b = 1'b1; act_b = 1'b0;
        tick();
        done_b = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_a = '0; byte_a = '0; act_a = 1'b0; done_a = 1'b0;
        valid_b = '0; byte_b = '0; act_b = 1'b0; done_b = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ptr_a = 0; ptr_b = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_a = 4'hF; byte_a = $urandom; act_a = 1'b0; done_a = 1'b0;
        valid_b = 3'h7; byte_b = 24'($urandom); act_b = 1'b0; done_b = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ready_a, gid_a, dv_a, txb_a, busy_a, to_a} !== 17'd0) begin
            failures++;
            $display("FAIL reset_a outputs got=%h exp=0", {ready_a, gid_a, dv_a, txb_a, busy_a, to_a});
        end
        checks++;
        if ({ready_b, gid_b, dv_b, txb_b, busy_b, to_b} !== 16'd0) begin
            failures++;
            $display("FAIL reset_b outputs got=%h exp=0", {ready_b, gid_b, dv_b, txb_b, busy_b, to_b});
        end
        valid_a = '0; valid_b = '0;
        rst_n = 1'b1;
        ptr_a = 0; ptr_b = 0;
        tick();
    endtask

    task automatic test_single();
        byte_a = $urandom;
        byte_a[15:8] = 8'hA5;
        valid_a = 4'b0010;
        tick();
        checks++;
        if ({ready_a, dv_a} !== {4'b0010, 1'b1}) begin
            failures++;
            $display("FAIL single_launch ready/dv got=%b/%b exp=0010/1", ready_a, dv_a);
        end
        checks++;
        if (txb_a !== 8'hA5 || gid_a !== 2'd1) begin
            failures++;
            $display("FAIL single_byte_grant got=%h/%0d exp=a5/1", txb_a, gid_a);
        end
        ptr_a = 2;
        valid_a = '0; act_a = 1'b1;
        tick();
        checks++;
        if ({ready_a, dv_a} !== 5'd0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL single_pulse_width ready/dv/busy got=%b/%b/%b exp=0000/0/1", ready_a, dv_a, busy_a);
        end
        repeat (9) tick();
        done_a = 1'b1; act_a = 1'b0;
        tick();
        done_a = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_in_gap got=%b exp=1", busy_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after_gap got=%b exp=0", busy_a);
        end
    endtask

    task automatic test_round_robin();
        int n, exp, extra;
        logic [7:0] cap;
        do_reset();
        byte_a = $urandom;
        valid_a = 4'hF;
        for (int f = 0; f < 16; f++) begin
            wait_dv_a(20, n);
            checks++;
            if (dv_a !== 1'b1) begin
                failures++;
                $display("FAIL rr_no_dv frame=%0d waited=%0d", f, n);
                return;
            end
            exp = rr_expect(8'(valid_a), ptr_a, 4);
            cap = byte_a[8*exp +: 8];
            checks++;
            if (gid_a !== 2'(exp) || ready_a !== 4'(1 << exp) || txb_a !== cap) begin
                failures++;
                $display("FAIL rr_grant frame=%0d got=%0d/%b/%h exp=%0d/%b/%h",
                         f, gid_a, ready_a, txb_a, exp, 4'(1 << exp), cap);
            end
            if (f < 5) begin
                checks++;
                if (gid_a !== 2'(f % 4)) begin
                    failures++;
                    $display("FAIL rr_order frame=%0d got=%0d exp=%0d", f, gid_a, f % 4);
                end
            end
            ptr_a = (exp + 1) % 4;
            byte_a[8*exp +: 8] = 8'($urandom);
            if (f >= 4) begin
                valid_a[exp] = 1'b0;
                valid_a = valid_a | 4'($urandom);
                if (valid_a == 4'd0) valid_a[$urandom_range(3)] = 1'b1;
            end
            act_a = 1'b1;
            extra = 0;
            repeat ($urandom_range(1, 20)) begin
                tick();
                if (dv_a !== 1'b0 || ready_a !== 4'd0 || txb_a !== cap) extra++;
            end
            done_a = 1'b1; act_a = 1'b0;
            tick();
            done_a = 1'b0;
            checks++;
            if (extra != 0) begin
                failures++;
                $display("FAIL rr_single_dv frame=%0d bad_cycles=%0d exp=0", f, extra);
            end
        end
        valid_a = '0;
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        int n, k, exp, t, pulses;
        do_reset();
        k = $urandom_range(3);
        byte_a = $urandom;
        valid_a = 4'((1 << k) | (1 << ((k + 1) % 4)));
        wait_dv_a(10, n);
        exp = rr_expect(8'(valid_a), ptr_a, 4);
        ptr_a = (exp + 1) % 4;
        valid_a[exp] = 1'b0;
        act_a = 1'b1;
        t = 0;
        while (to_a !== 1'b1 && t < 100) begin tick(); t++; end
        checks++;
        if (to_a !== 1'b1 || t != 51) begin
            failures++;
            $display("FAIL timeout_latency got=%0d clocks (to=%b) exp=51", t, to_a);
        end
        tick();
        checks++;
        if (to_a !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width got=%b exp=0", to_a);
        end
        act_a = 1'b0;
        wait_dv_a(20, n);
        exp = rr_expect(8'(valid_a), ptr_a, 4);
        checks++;
        if (dv_a !== 1'b1 || gid_a !== 2'(exp) || txb_a !== byte_a[8*exp +: 8]) begin
            failures++;
            $display("FAIL timeout_next_grant got=%b/%0d/%h exp=1/%0d/%h",
                     dv_a, gid_a, txb_a, exp, byte_a[8*exp +: 8]);
        end
        ptr_a = (exp + 1) % 4;
        valid_a[exp] = 1'b0;
        act_a = 1'b1;
        repeat (50) tick();
        done_a = 1'b1; act_a = 1'b0;
        pulses = 0;
        tick();
        done_a = 1'b0;
        if (to_a !== 1'b0) pulses++;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL done_last_cycle_gap busy got=%b exp=1", busy_a);
        end
        repeat (60) begin
            tick();
            if (to_a !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL done_last_cycle_timeout got=%0d pulses exp=0", pulses);
        end
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || dv_a !== 1'b0 || to_a !== 1'b0) begin
            failures++;
            $display("FAIL done_ignored_idle busy/dv/to got=%b/%b/%b exp=0/0/0", busy_a, dv_a, to_a);
        end
    endtask

    task automatic test_reset_midframe();
        int n, exp, bad;
        do_reset();
        byte_a = $urandom;
        valid_a = 4'($urandom);
        if (valid_a == 4'd0) valid_a = 4'b1000;
        wait_dv_a(10, n);
        exp = rr_expect(8'(valid_a), ptr_a, 4);
        valid_a[exp] = 1'b0;
        valid_a[(exp + 2) % 4] = 1'b1;
        act_a = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ready_a, gid_a, dv_a, txb_a, busy_a, to_a} !== 17'd0) begin
            failures++;
            $display("FAIL midframe_reset outputs got=%h exp=0", {ready_a, gid_a, dv_a, txb_a, busy_a, to_a});
        end
        rst_n = 1'b1;
        ptr_a = 0;
        bad = 0;
        repeat (6) begin
            tick();
            if (dv_a !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midframe_gate dv while active got=%0d cycles exp=0", bad);
        end
        act_a = 1'b0;
        tick();
        exp = rr_expect(8'(valid_a), ptr_a, 4);
        checks++;
        if (dv_a !== 1'b1 || gid_a !== 2'(exp)) begin
            failures++;
            $display("FAIL midframe_resume dv/grant got=%b/%0d exp=1/%0d", dv_a, gid_a, exp);
        end
        valid_a = '0;
        finish_a(4);
        repeat (6) tick();
    endtask

    task automatic test_gap();
        int n, exp;
        do_reset();
        byte_a = $urandom;
        valid_a = 4'b0011;
        wait_dv_a(10, n);
        exp = rr_expect(8'(valid_a), ptr_a, 4);
        ptr_a = (exp + 1) % 4;
        act_a = 1'b1;
        repeat (3) tick();
        done_a = 1'b1; act_a = 1'b0;
        tick();
        done_a = 1'b0;
        n = 1;
        while (!dv_a && n < 20) begin tick(); n++; end
        checks++;
        if (dv_a !== 1'b1 || n != 5) begin
            failures++;
            $display("FAIL gap3_done_to_dv got=%0d clocks exp=5", n);
        end
        valid_a = '0;
        finish_a(3);

        byte_b = 24'($urandom);
        valid_b = 3'b011;
        wait_dv_b(10, n);
        exp = rr_expect(8'(valid_b), ptr_b, 3);
        ptr_b = (exp + 1) % 3;
        act_b = 1'b1;
        repeat (3) tick();
        done_b = 1'b1; act_b = 1'b0;
        tick();
        done_b = 1'b0;
        n = 1;
        while (!dv_b && n < 20) begin tick(); n++; end
        checks++;
        if (dv_b !== 1'b1 || n != 2) begin
            failures++;
            $display("FAIL gap0_done_to_dv got=%0d clocks exp=2", n);
        end
        valid_b = '0;
        finish_b(3);
        repeat (6) tick();
    endtask

    task automatic test_wrap();
        int n, exp;
        do_reset();
        byte_a = $urandom;
        valid_a = 4'b0100;
        wait_dv_a(10, n);
        checks++;
        if (dv_a !== 1'b1 || gid_a !== 2'd2) begin
            failures++;
            $display("FAIL wrap4_first got=%b/%0d exp=1/2", dv_a, gid_a);
        end
        valid_a = 4'b0101;
        finish_a(2);
        for (int f = 0; f < 2; f++) begin
            wait_dv_a(20, n);
            checks++;
            if (dv_a !== 1'b1 || gid_a !== 2'(f * 2)) begin
                failures++;
                $display("FAIL wrap4_order step=%0d got=%b/%0d exp=1/%0d", f, dv_a, gid_a, f * 2);
            end
            valid_a[f * 2] = 1'b0;
            finish_a(2);
        end

        byte_b = 24'($urandom);
        valid_b = 3'b100;
        wait_dv_b(10, n);
        checks++;
        if (dv_b !== 1'b1 || gid_b !== 2'd2) begin
            failures++;
            $display("FAIL wrap3_first got=%b/%0d exp=1/2", dv_b, gid_b);
        end
        ptr_b = 0;
        valid_b = 3'b111;
        finish_b(2);
        wait_dv_b(10, n);
        checks++;
        if (dv_b !== 1'b1 || gid_b !== 2'd0) begin
            failures++;
            $display("FAIL wrap3_to_zero got=%b/%0d exp=1/0", dv_b, gid_b);
        end
        // Randomized traffic on the 3-requester build against the model.
        for (int f = 0; f < 12; f++) begin
            wait_dv_b(10, n);
            exp = rr_expect(8'(valid_b), ptr_b, 3);
            checks++;
            if (dv_b !== 1'b1 || gid_b !== 2'(exp) || ready_b !== 3'(1 << exp)
                || txb_b !== byte_b[8*exp +: 8]) begin
                failures++;
                $display("FAIL rr3_grant frame=%0d got=%b/%0d/%b/%h exp=1/%0d/%b/%h",
                         f, dv_b, gid_b, ready_b, txb_b, exp, 3'(1 << exp), byte_b[8*exp +: 8]);
            end
            ptr_b = (exp + 1) % 3;
            valid_b[exp] = 1'b0;
            valid_b = valid_b | 3'($urandom);
            if (valid_b == 3'd0) valid_b[$urandom_range(2)] = 1'b1;
            byte_b[8*exp +: 8] = 8'($urandom);
            finish_b($urandom_range(1, 8));
        end
        valid_b = '0;
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL tb_watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid_a = '0; byte_a = '0; act_a = 1'b0; done_a = 1'b0;
        valid_b = '0; byte_b = '0; act_b = 1'b0; done_b = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_midframe();
        test_gap();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
